// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Clock edges from the start-sampling edge to the edge that raises done.
  function automatic int LATENCY(input int width);
    return width + 1;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes, MSB of the dividend first.
// dvd_next is the dividend shifted left with its LSB left clear for the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dvd_next,
  output logic             qbit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // With a nonzero divisor rem < divisor <= 2^(WIDTH-1), so WIDTH+1 bits hold the trial sign.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    qbit     = ~trial[WIDTH];
    rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: magnitudes are divided by restoring steps, signs applied at the end.
// Fixed latency of WIDTH+1 edges from start to done, independent of the operands.
module seq_signed_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_n;
  logic             load;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dsr, dividend;
  logic             neg_q, neg_r, zero_div;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] rem_next, dvd_next;
  logic             qbit;

  // Unsigned negation keeps |-2^(WIDTH-1)| exact as 2^(WIDTH-1).
  assign mag1 = in1[WIDTH-1] ? -in1 : in1;
  assign mag2 = in2[WIDTH-1] ? -in2 : in2;
  assign busy = (state != IDLE);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd      (dvd),
    .divisor  (dsr),
    .rem_next (rem_next),
    .dvd_next (dvd_next),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load    = 1'b1;
        state_n = CALC;
      end
      CALC: if (cnt == '0) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      dividend    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          rem      <= '0;
          dvd      <= mag1;
          dsr      <= mag2;
          dividend <= in1;
          neg_q    <= in1[WIDTH-1] ^ in2[WIDTH-1];
          neg_r    <= in1[WIDTH-1];
          zero_div <= (in2 == '0);
          cnt      <= CW'(WIDTH - 1);
        end
        CALC: begin
          // The dividend register fills with quotient bits as it shifts out.
          rem <= rem_next;
          dvd <= dvd_next | WIDTH'(qbit);
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= zero_div;
          if (zero_div) begin
            quotient  <= '1;
            remainder <= dividend;
          end else begin
            quotient  <= neg_q ? -dvd : dvd;
            remainder <= neg_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and random checks of the sequential signed divider (WIDTH=32).
module tb_seq_signed_divider;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] in1, in2;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; results sampled at the done negedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit now,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int busy_cyc, output logic busy_at_done);
    if (!now) @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in1 = $urandom; in2 = $urandom;
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_cyc++;
    end
    q = quotient; r = remainder; dz = div_by_zero; busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b expected 0", done); end
    vectors++; if (quotient !== 32'h0) begin miscompares++; $display("FAIL reset quotient: got %h expected 0", quotient); end
    vectors++; if (remainder !== 32'h0) begin miscompares++; $display("FAIL reset remainder: got %h expected 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset div_by_zero: got %b expected 0", div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_positive();
    logic [31:0] q, r; logic dz, bd; int lat, bc;
    run_op(32'd100, 32'd7, 1'b0, q, r, dz, lat, bc, bd);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL pos latency: got %0d expected 33", lat); end
    vectors++; if (bc != 33) begin miscompares++; $display("FAIL pos busy cycles: got %0d expected 33", bc); end
    vectors++; if (bd !== 1'b0) begin miscompares++; $display("FAIL pos busy at done: got %b expected 0", bd); end
    vectors++; if (q !== 32'd14) begin miscompares++; $display("FAIL pos quotient: got %h expected %h", q, 32'd14); end
    vectors++; if (r !== 32'd2) begin miscompares++; $display("FAIL pos remainder: got %h expected %h", r, 32'd2); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL pos div_by_zero: got %b expected 0", dz); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL pos done pulse width: got %b expected 0", done); end
  endtask

  // Sign combinations and extremes share one table: dividend, divisor, quotient, remainder.
  task automatic test_signs_extremes();
    logic [31:0] ta[8], tb[8], tq[8], tr[8];
    logic [31:0] q, r; logic dz, bd; int lat, bc;
    ta = '{-32'd100, 32'd100, -32'd100, 32'd0, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd1};
    tb = '{32'd7, -32'd7, -32'd7, 32'd5, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd1};
    tq = '{-32'd14, -32'd14, 32'd14, 32'd0, 32'h80000000, 32'h80000000, 32'd0, 32'd1};
    tr = '{-32'd2, 32'd2, -32'd2, 32'd0, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd0};
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], 1'b0, q, r, dz, lat, bc, bd);
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL tbl%0d latency: got %0d expected 33", i, lat); end
      vectors++; if (q !== tq[i]) begin miscompares++; $display("FAIL tbl%0d quotient %h/%h: got %h expected %h", i, ta[i], tb[i], q, tq[i]); end
      vectors++; if (r !== tr[i]) begin miscompares++; $display("FAIL tbl%0d remainder %h/%h: got %h expected %h", i, ta[i], tb[i], r, tr[i]); end
      vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL tbl%0d div_by_zero: got %b expected 0", i, dz); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r; logic dz, bd; int lat, bc;
    run_op(-32'd55, 32'd0, 1'b0, q, r, dz, lat, bc, bd);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL dz latency: got %0d expected 33", lat); end
    vectors++; if (q !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dz quotient: got %h expected ffffffff", q); end
    vectors++; if (r !== -32'd55) begin miscompares++; $display("FAIL dz remainder: got %h expected %h", r, -32'd55); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz flag: got %b expected 1", dz); end
    run_op(32'd9, 32'd3, 1'b0, q, r, dz, lat, bc, bd);
    vectors++; if (q !== 32'd3) begin miscompares++; $display("FAIL dz-after quotient: got %h expected 3", q); end
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL dz-after remainder: got %h expected 0", r); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL dz-after flag: got %b expected 0", dz); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    in1 = 32'd20; in2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) break;
      if (lat == 5) begin start = 1'b1; in1 = 32'd50; in2 = 32'd5; end
      else start = 1'b0;
    end
    start = 1'b0;
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL ignore latency: got %0d expected 33", lat); end
    vectors++; if (quotient !== 32'd6) begin miscompares++; $display("FAIL ignore quotient: got %h expected 6", quotient); end
    vectors++; if (remainder !== 32'd2) begin miscompares++; $display("FAIL ignore remainder: got %h expected 2", remainder); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r; logic dz, bd; int lat, bc;
    run_op(32'd20, 32'd3, 1'b0, q, r, dz, lat, bc, bd);
    vectors++; if (q !== 32'd6) begin miscompares++; $display("FAIL b2b first quotient: got %h expected 6", q); end
    run_op(32'd50, 32'd5, 1'b1, q, r, dz, lat, bc, bd);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL b2b latency: got %0d expected 33", lat); end
    vectors++; if (q !== 32'd10) begin miscompares++; $display("FAIL b2b quotient: got %h expected a", q); end
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL b2b remainder: got %h expected 0", r); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] q, r; logic dz, bd; int lat, bc, pulses;
    @(negedge clk);
    in1 = 32'd77; in2 = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst done: got %b expected 0", done); end
    vectors++; if (quotient !== 32'd0) begin miscompares++; $display("FAIL midrst quotient: got %h expected 0", quotient); end
    vectors++; if (remainder !== 32'd0) begin miscompares++; $display("FAIL midrst remainder: got %h expected 0", remainder); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    vectors++; if (pulses != 0) begin miscompares++; $display("FAIL midrst activity after abort: got %0d expected 0", pulses); end
    run_op(32'd1000, 32'd10, 1'b0, q, r, dz, lat, bc, bd);
    vectors++; if (lat != 33) begin miscompares++; $display("FAIL postrst latency: got %0d expected 33", lat); end
    vectors++; if (q !== 32'd100) begin miscompares++; $display("FAIL postrst quotient: got %h expected 64", q); end
    vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL postrst remainder: got %h expected 0", r); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r, eq, er, id; logic dz, edz, bd; int lat, bc;
    longint la, lb;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      case (i % 5)
        0: b = $urandom;
        1: b = 32'($urandom_range(0, 20)) - 32'd10;
        2: begin a = 32'($urandom_range(0, 2000)) - 32'd1000; b = 32'($urandom_range(0, 60)) - 32'd30; end
        3: b = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h80000000;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 37 == 0) a = 32'h80000000;
      la = longint'($signed(a)); lb = longint'($signed(b));
      if (lb == 0) begin eq = 32'hFFFFFFFF; er = a; edz = 1'b1; end
      else begin eq = 32'(la / lb); er = 32'(la % lb); edz = 1'b0; end
      run_op(a, b, 1'b0, q, r, dz, lat, bc, bd);
      id = q * b + r;
      vectors++; if (q !== eq) begin miscompares++; $display("FAIL rnd%0d quotient %h/%h: got %h expected %h", i, a, b, q, eq); end
      vectors++; if (r !== er) begin miscompares++; $display("FAIL rnd%0d remainder %h/%h: got %h expected %h", i, a, b, r, er); end
      vectors++; if (dz !== edz) begin miscompares++; $display("FAIL rnd%0d div_by_zero: got %b expected %b", i, dz, edz); end
      vectors++; if (id !== a) begin miscompares++; $display("FAIL rnd%0d identity q*in2+r: got %h expected %h", i, id, a); end
      vectors++; if (lat != 33) begin miscompares++; $display("FAIL rnd%0d latency: got %0d expected 33", i, lat); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_positive();
    test_signs_extremes();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
